// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: joystick conditioning, coin pulse shaping, pause and video dim control
module arcade_input_ctrl #(
  parameter int COIN_PULSE = 1500000,
  parameter int COIN_GAP   = 3000000,
  parameter int DIM_DELAY  = 300000000,
  parameter int CNT_W      = 32
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        osd_status,
  input  logic        osd_pause_en,
  input  logic        hs_access,
  output logic [7:0]  joy1_out,
  output logic [7:0]  joy2_out,
  output logic        pause,
  output logic        dim_video,
  output logic [1:0]  coin_busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_PULSE = 2'd1, S_GAP = 2'd2, S_REL = 2'd3;
  logic [9:0]       w_j;
  logic [1:0]       w_coin_raw;
  logic [1:0]       w_coin;
  logic [1:0]       w_busy;
  logic [1:0]       r_coin_prev;
  logic [6:0]       r_joy1;
  logic [6:0]       r_joy2;
  logic             r_pause_prev;
  logic             r_toggle;
  logic             r_pause;
  logic             r_dim;
  logic [CNT_W-1:0] r_dim_cnt;
  logic             w_unused;
  assign w_j        = joystick_0[9:0] | joystick_1[9:0];
  assign w_coin_raw = {joystick_1[8], joystick_0[8]};
  assign w_unused   = ^{joystick_0[15:10], joystick_1[15:10], w_j[8]};
  // Controls, edge-detect history, pause toggle and the saturating dim timer
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_joy1       <= '0;
      r_joy2       <= '0;
      r_coin_prev  <= '0;
      r_pause_prev <= 1'b0;
      r_toggle     <= 1'b0;
      r_pause      <= 1'b0;
      r_dim_cnt    <= '0;
      r_dim        <= 1'b0;
    end else begin
      r_joy1       <= w_j[6:0];
      r_joy2       <= {w_j[7], w_j[5:0]};
      r_coin_prev  <= w_coin_raw;
      r_pause_prev <= w_j[9];
      r_toggle     <= r_toggle ^ (w_j[9] & ~r_pause_prev);
      r_pause      <= hs_access | r_toggle | (osd_status & osd_pause_en);
      r_dim_cnt    <= !r_toggle ? '0 : (r_dim_cnt == CNT_W'(DIM_DELAY)) ? r_dim_cnt : r_dim_cnt + 1'b1;
      r_dim        <= r_toggle & (r_dim_cnt == CNT_W'(DIM_DELAY));
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_coin
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pulse;
    logic             w_act;
    // Coin FSM state and shared pulse/lockout counter
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
    // Next state: one pulse per press, then lockout, then wait for button release
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        S_IDLE: if (w_coin_raw[g] & ~r_coin_prev[g]) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = CNT_W'(COIN_PULSE - 1);
        end
        S_PULSE: if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_W'(COIN_GAP - 1);
        end else w_cnt_nxt = r_cnt - 1'b1;
        S_GAP: if (r_cnt == '0) w_state_nxt = S_REL;
        else w_cnt_nxt = r_cnt - 1'b1;
        default: if (!w_coin_raw[g]) w_state_nxt = S_IDLE;
      endcase
    end
    // Outputs decoded from state
    always_comb begin
      w_pulse = r_state == S_PULSE;
      w_act   = r_state != S_IDLE;
    end
    assign w_coin[g] = w_pulse;
    assign w_busy[g] = w_act;
  end
  assign joy1_out  = {w_coin[0], r_joy1};
  assign joy2_out  = {w_coin[1], r_joy2};
  assign pause     = r_pause;
  assign dim_video = r_dim;
  assign coin_busy = w_busy;
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb_arcade_input_ctrl: directed checks of mapping, coin shaping, pause and dim
module tb_arcade_input_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        osd_status;
  logic        osd_pause_en;
  logic        hs_access;
  logic [7:0]  joy1_out;
  logic [7:0]  joy2_out;
  logic        pause;
  logic        dim_video;
  logic [1:0]  coin_busy;
  int          n_chk = 0;
  int          n_err = 0;
  arcade_input_ctrl #(.COIN_PULSE(4), .COIN_GAP(6), .DIM_DELAY(10), .CNT_W(32)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .joystick_0(joystick_0), .joystick_1(joystick_1),
    .osd_status(osd_status), .osd_pause_en(osd_pause_en), .hs_access(hs_access),
    .joy1_out(joy1_out), .joy2_out(joy2_out), .pause(pause), .dim_video(dim_video),
    .coin_busy(coin_busy)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic do_reset();
    joystick_0 = '0; joystick_1 = '0; osd_status = 0; osd_pause_en = 0; hs_access = 0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask
  initial begin
    int c1, c2, rises;
    logic prev;
    reset_n = 0;
    joystick_0 = 16'hFFFF; joystick_1 = 16'hFFFF;
    osd_status = 1; osd_pause_en = 1; hs_access = 1;
    repeat (3) tick();
    chk("rst_joy1", joy1_out, 8'h00);
    chk("rst_joy2", joy2_out, 8'h00);
    chk("rst_pause", pause, 0);
    chk("rst_dim", dim_video, 0);
    chk("rst_busy", coin_busy, 2'b00);
    reset_n = 1;
    #1;
    chk("rel_joy1", joy1_out, 8'h00);
    chk("rel_busy", coin_busy, 2'b00);
    c1 = 0; c2 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin
        chk("held_joy1", joy1_out, 8'hFF);
        chk("held_joy2", joy2_out, 8'hFF);
      end
      c1 += joy1_out[7];
      c2 += joy2_out[7];
    end
    chk("held_coin1_len", c1, 4);
    chk("held_coin2_len", c2, 4);
    chk("held_busy", coin_busy, 2'b11);
    do_reset();
    joystick_0[8] = 1;
    c1 = 0; c2 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) chk("coin1_rise", joy1_out[7], 1);
      if (i == 4) chk("coin1_fall", joy1_out[7], 0);
      c1 += joy1_out[7];
      c2 += joy2_out[7];
    end
    chk("coin1_len", c1, 4);
    chk("coin2_quiet", c2, 0);
    chk("busy_while_held", coin_busy, 2'b01);
    joystick_0[8] = 0;
    tick();
    chk("busy_after_release", coin_busy, 2'b00);
    c1 = 0; c2 = 0; rises = 0; prev = 0;
    for (int i = 0; i < 30; i++) begin
      joystick_1[8] = (i < 3) || (i >= 6 && i < 9);
      tick();
      c1 += joy1_out[7];
      c2 += joy2_out[7];
      if (joy2_out[7] && !prev) rises++;
      prev = joy2_out[7];
    end
    chk("lock_coin2_len", c2, 4);
    chk("lock_coin2_rises", rises, 1);
    chk("lock_coin1_quiet", c1, 0);
    chk("lock_busy_idle", coin_busy, 2'b00);
    c2 = 0;
    for (int i = 0; i < 8; i++) begin
      joystick_1[8] = i < 2;
      tick();
      if (i == 0) chk("coin2_again_rise", joy2_out[7], 1);
      c2 += joy2_out[7];
    end
    chk("coin2_again_len", c2, 4);
    do_reset();
    joystick_1 = 16'h00B1;
    #1;
    chk("map_latency", joy2_out, 8'h00);
    tick();
    chk("map_b1_joy1", joy1_out, 8'h31);
    chk("map_b1_joy2", joy2_out, 8'h71);
    joystick_1 = 16'h0000;
    tick();
    chk("map_clear_joy1", joy1_out, 8'h00);
    chk("map_clear_joy2", joy2_out, 8'h00);
    joystick_0 = 16'h004E;
    tick();
    chk("map_4e_joy1", joy1_out, 8'h4E);
    chk("map_4e_joy2", joy2_out, 8'h0E);
    joystick_0 = 16'h0001; joystick_1 = 16'h0080;
    tick();
    chk("map_or_joy1", joy1_out, 8'h01);
    chk("map_or_joy2", joy2_out, 8'h41);
    joystick_0 = 0; joystick_1 = 0;
    tick();
    joystick_0[9] = 1;
    tick();
    chk("pause_reg_lat", pause, 0);
    joystick_0[9] = 0;
    tick();
    chk("pause_on", pause, 1);
    repeat (9) tick();
    chk("dim_not_yet", dim_video, 0);
    tick();
    chk("dim_on", dim_video, 1);
    repeat (20) tick();
    chk("dim_sat", dim_video, 1);
    joystick_1[9] = 1;
    tick();
    joystick_1[9] = 0;
    tick();
    chk("unpause", pause, 0);
    chk("undim", dim_video, 0);
    hs_access = 1;
    tick(); tick();
    chk("hs_pause", pause, 1);
    hs_access = 0; joystick_0[9] = 1;
    tick();
    joystick_0[9] = 0;
    tick();
    chk("toggle_with_hs_change", pause, 1);
    joystick_0[9] = 1;
    tick();
    joystick_0[9] = 0;
    tick();
    chk("toggle_off", pause, 0);
    osd_status = 1; osd_pause_en = 0;
    tick(); tick();
    chk("osd_no_en", pause, 0);
    osd_pause_en = 1;
    tick();
    chk("osd_en", pause, 1);
    osd_status = 0; osd_pause_en = 0; hs_access = 1;
    repeat (15) tick();
    chk("hs_only_pause", pause, 1);
    chk("hs_only_no_dim", dim_video, 0);
    hs_access = 0;
    tick();
    chk("hs_off", pause, 0);
    joystick_0[8] = 1;
    tick(); tick();
    chk("mid_pulse_high", joy1_out[7], 1);
    reset_n = 0;
    #1;
    chk("mid_pulse_abort", joy1_out, 8'h00);
    chk("mid_pulse_busy", coin_busy, 2'b00);
    joystick_0 = 0;
    tick();
    reset_n = 1;
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
